mult_sequencer: RTL and testbench
=================================

Name: mult_sequencer

Overview:
- Controller that sequences the shared pair of 8x8 multipliers and their byte-select operand mux through a multi-cycle element-wise multiply of two 32-bit words.
- Latches operands and SEW, then drives the operand mux selects (count_16bit, count_32bit) cycle by cycle.
- Shift-accumulates the two 16-bit partial products and returns the low-SEW-bits result per element over a valid/ready handshake.
- Sits between the vector execute issue logic and the multiplier datapath; all arithmetic is unsigned.

Parameters:
- DATA_W, 32, operand/result width; only 32 supported.
- PROD_W, 16, width of each 8x8 multiplier product.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept (high only in IDLE)
- in_a  input  32  operand A
- in_b  input  32  operand B
- in_sew  input  2  00=8b, 01=16b, 10=32b, 11=illegal
- flush  input  1  synchronous abort to IDLE
- op_a  output  32  latched A to operand mux
- op_b  output  32  latched B to operand mux
- sew_o  output  2  latched SEW to operand mux
- count_16bit  output  2  mux select: [0]=A byte (sew 00/01), [1]=B byte (sew 01)
- count_32bit  output  4  mux select: [1:0]=A byte, [3:2]=B byte (sew 10)
- mult1_p  input  16  product of multiplier 1, combinational in the same cycle
- mult2_p  input  16  product of multiplier 2, combinational in the same cycle
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_result  output  32  packed element results
- out_err  output  1  illegal SEW flag, qualified by out_valid
- busy  output  1  state != IDLE

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - op_a, op_b, sew_o, counts, accumulators, out_result, out_err, out_valid all go to 0.
  - in_ready=1 and busy=0.
- States:
  - IDLE: in_valid&&in_ready -> latch in_a/in_b/in_sew, clear accumulator, clear counter k, go to BUSY.
  - BUSY: one partial-product step per cycle. At k==N-1, go to DONE. The result register updates on that same edge.
  - DONE: out_valid=1. On out_ready go to IDLE.
- Step counts N: sew00=2, sew01=4, sew10=16, sew11=1.
- Latency: accept at edge T; out_valid high from cycle T+N+1. No accept in the DONE->IDLE transition cycle.
- Selects are driven from k during BUSY and are 0 in other states.
  - sew00: count_16bit={1'b0,k[0]}.
  - sew01: count_16bit=k[1:0].
  - sew10: count_32bit=k[3:0].
- Accumulation, with a = A byte index and b = B byte index:
  - sew00, step k: result byte k = mult1_p[7:0]; byte k+2 = mult2_p[7:0]. Lanes are independent.
  - sew01: a=k[0], b=k[1], sh=8*(a+b).
    - lo16 += (mult1_p<<sh) mod 2^16.
    - hi16 += (mult2_p<<sh) mod 2^16.
    - Carries never cross lanes.
  - sew10: a=k[1:0], b=k[3:2], acc32 += (mult1_p << 8*(a+b)) mod 2^32. mult2_p is ignored.
  - sew11: result 0, out_err=1, N=1.
- Handshake and holding:
  - out_result/out_err are held stable while out_valid && !out_ready.
  - in_ready=0 from accept until the cycle after the result is consumed.
  - in_valid while not in IDLE is ignored; the requester must hold it.
- flush:
  - Synchronous; overrides all other events. Any state goes to IDLE with counts 0 and out_valid 0.
  - An accumulator that is not reused is not cleared.
  - flush with in_valid in IDLE: flush wins, nothing accepted.
- Reset mid-operation: the result is discarded and no out_valid follows.
- Inputs in_a/in_b/in_sew may change after accept without effect.

Decomposition:
- Package mult_pkg:
  - sew_e enum (SEW8, SEW16, SEW32, SEW_ILL)
  - seq_state_e (IDLE, BUSY, DONE)
  - step-count constants N8=2, N16=4, N32=16
  - shift-amount function sh(a,b)
- Sub-module mult_accum: SEW-aware lane-segmented shift-add accumulator.
  - Inputs: k, sew, mult1_p, mult2_p, clear, enable.
  - Output: 32-bit result.
- Top holds the FSM, step counter, operand registers and handshake.

Test Plan:
- sew00, A=0x04030201, B=0x05050505 -> out_result=0x140F0A05, out_err=0, out_valid at T+3, count_16bit sequence 00,01.
- sew01, A=0xFFFF1234, B=0x00020010 -> out_result=0xFFFE2340 (lane truncation, no cross-lane carry), count_16bit sequence 00,01,10,11.
- sew10, A=0x12345678, B=0x00000010 -> 0x23456780. Then A=B=0xFFFFFFFF -> 0x00000001. out_valid at T+17; count_32bit walks 0..15.
- Backpressure: after a sew10 result, hold out_ready=0 for 5 cycles -> out_result stable, in_ready=0, an asserted in_valid is not accepted. out_ready=1 -> IDLE next cycle.
- Reset at step k=5 of sew10 -> all outputs 0 immediately. After release, in_ready=1, no out_valid; a new sew00 request completes correctly.
- sew11 request -> out_valid at T+2 with out_result=0 and out_err=1. Separately, flush at BUSY step 2 of sew01 -> IDLE next cycle, no out_valid.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the multi-cycle element-wise multiply sequencer.
package mult_pkg;

  typedef enum logic [1:0] {
    SEW8    = 2'b00,
    SEW16   = 2'b01,
    SEW32   = 2'b10,
    SEW_ILL = 2'b11
  } sew_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } seq_state_e;

  // Partial-product steps per element width
  localparam int N8  = 2;
  localparam int N16 = 4;
  localparam int N32 = 16;

  // Byte-position shift of an 8x8 product: A byte a times B byte b lands at 8*(a+b)
  function automatic logic [5:0] sh(input logic [1:0] a, input logic [1:0] b);
    return {3'(a) + 3'(b), 3'b000};
  endfunction

  // Final step index for a SEW; illegal SEW takes a single dummy step
  function automatic logic [3:0] last_step(input sew_e s);
    case (s)
      SEW8:    return 4'(N8 - 1);
      SEW16:   return 4'(N16 - 1);
      SEW32:   return 4'(N32 - 1);
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/mult_sequencer_if.sv
// Request/response handshake between issue logic and the multiply sequencer.
interface mult_sequencer_if #(parameter int DATA_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [1:0]        in_sew;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_err;

  modport master (
    output in_valid, in_a, in_b, in_sew, out_ready,
    input  in_ready, out_valid, out_result, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sew, out_ready,
    output in_ready, out_valid, out_result, out_err
  );
endinterface

// File: rtl/mult_accum.sv
// SEW-aware shift-add accumulator; lanes are segmented so carries never cross elements.
module mult_accum
  import mult_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PROD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic [3:0]        k,
  input  sew_e              sew,
  input  logic [PROD_W-1:0] mult1_p,
  input  logic [PROD_W-1:0] mult2_p,
  output logic [DATA_W-1:0] result   // accumulator value after the current step
);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [5:0]        s;
  logic [PROD_W-1:0] p1_lane, p2_lane;
  logic [DATA_W-1:0] p1_wide;

  // Shifted partial products; 16-bit lanes truncate naturally at the lane width
  always_comb begin
    s       = (sew == SEW32) ? sh(k[1:0], k[3:2]) : sh({1'b0, k[0]}, {1'b0, k[1]});
    p1_lane = mult1_p << s;
    p2_lane = mult2_p << s;
    p1_wide = DATA_W'(mult1_p) << s;
  end

  // Next accumulator value per element width
  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (enable) begin
      case (sew)
        SEW8: begin
          // byte lanes are written, not summed: one product per byte
          if (!k[0]) begin
            acc_d[7:0]   = mult1_p[7:0];
            acc_d[23:16] = mult2_p[7:0];
          end else begin
            acc_d[15:8]  = mult1_p[7:0];
            acc_d[31:24] = mult2_p[7:0];
          end
        end
        SEW16: begin
          acc_d[15:0]  = acc_q[15:0]  + p1_lane;
          acc_d[31:16] = acc_q[31:16] + p2_lane;
        end
        SEW32:   acc_d = acc_q + p1_wide;
        default: acc_d = '0;
      endcase
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign result = acc_d;

endmodule

// File: rtl/mult_sequencer.sv
// Sequences the shared 8x8 multiplier pair through an element-wise 32-bit multiply.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PROD_W = 16
) (
  input  logic              clk,
  input  logic              reset,      // async, active low
  mult_sequencer_if.slave   bus,
  input  logic              flush,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [1:0]        sew_o,
  output logic [1:0]        count_16bit,
  output logic [3:0]        count_32bit,
  input  logic [PROD_W-1:0] mult1_p,
  input  logic [PROD_W-1:0] mult2_p,
  output logic              busy
);

  seq_state_e        state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  sew_e              sew_q, sew_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              err_q, err_d;
  logic              acc_clear, acc_en;
  logic [DATA_W-1:0] acc_sum;

  mult_accum #(.DATA_W(DATA_W), .PROD_W(PROD_W)) u_accum (
    .clk     (clk),
    .rst_n   (reset),
    .clear   (acc_clear),
    .enable  (acc_en),
    .k       (k_q),
    .sew     (sew_q),
    .mult1_p (mult1_p),
    .mult2_p (mult2_p),
    .result  (acc_sum)
  );

  // Next state, step counter, operand latch and result capture; flush overrides everything
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    sew_d     = sew_q;
    res_d     = res_q;
    err_d     = err_q;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_a_d    = bus.in_a;
          op_b_d    = bus.in_b;
          sew_d     = sew_e'(bus.in_sew);
          k_d       = '0;
          acc_clear = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        acc_en = 1'b1;
        if (k_q == last_step(sew_q)) begin
          res_d   = (sew_q == SEW_ILL) ? '0 : acc_sum;
          err_d   = (sew_q == SEW_ILL);
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d   = IDLE;
      k_d       = '0;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      sew_d     = sew_q;
      res_d     = res_q;
      err_d     = err_q;
      acc_clear = 1'b0;
      acc_en    = 1'b0;
    end
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sew_q   <= SEW8;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sew_q   <= sew_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Operand mux selects follow k only while stepping
  always_comb begin
    count_16bit = '0;
    count_32bit = '0;
    if (state_q == BUSY) begin
      case (sew_q)
        SEW8:    count_16bit = {1'b0, k_q[0]};
        SEW16:   count_16bit = k_q[1:0];
        SEW32:   count_32bit = k_q;
        default: ;
      endcase
    end
  end

  assign op_a           = op_a_q;
  assign op_b           = op_b_q;
  assign sew_o          = sew_q;
  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_result = res_q;
  assign bus.out_err    = err_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: models the operand mux + 8x8 multipliers and checks
// results against plain lane-wise arithmetic.
module tb_mult_sequencer;
  import mult_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] op_a, op_b;
  logic [1:0]  sew_o, c16;
  logic [3:0]  c32;
  logic [15:0] m1, m2;
  logic        busy;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [1:0]  q16[$];
  logic [3:0]  q32[$];

  mult_sequencer_if bus ();

  mult_sequencer dut (
    .clk(clk), .reset(rst_n), .bus(bus), .flush(flush),
    .op_a(op_a), .op_b(op_b), .sew_o(sew_o),
    .count_16bit(c16), .count_32bit(c32),
    .mult1_p(m1), .mult2_p(m2), .busy(busy)
  );

  always #5 clk = ~clk;

  // Operand byte mux feeding two 8x8 multipliers
  always_comb begin
    m1 = 16'h0;
    m2 = 16'h0;
    case (sew_o)
      2'b00: begin
        m1 = 16'(op_a[8*c16[0] +: 8]) * 16'(op_b[8*c16[0] +: 8]);
        m2 = 16'(op_a[16+8*c16[0] +: 8]) * 16'(op_b[16+8*c16[0] +: 8]);
      end
      2'b01: begin
        m1 = 16'(op_a[8*c16[0] +: 8]) * 16'(op_b[8*c16[1] +: 8]);
        m2 = 16'(op_a[16+8*c16[0] +: 8]) * 16'(op_b[16+8*c16[1] +: 8]);
      end
      2'b10: begin
        m1 = 16'(op_a[8*c32[1:0] +: 8]) * 16'(op_b[8*c32[3:2] +: 8]);
        m2 = 16'hFFFF;
      end
      default: begin
        m1 = 16'hABCD;
        m2 = 16'h1234;
      end
    endcase
  end

  // Reference: element-wise unsigned product truncated to the element width
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sew);
    logic [31:0] r;
    r = '0;
    case (sew)
      2'b00: for (int i = 0; i < 4; i++) r[8*i +: 8] = a[8*i +: 8] * b[8*i +: 8];
      2'b01: for (int i = 0; i < 2; i++) r[16*i +: 16] = a[16*i +: 16] * b[16*i +: 16];
      2'b10: r = a * b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int steps(input logic [1:0] sew);
    case (sew)
      2'b00: return 2;
      2'b01: return 4;
      2'b10: return 16;
      default: return 1;
    endcase
  endfunction

  // Present one request at a negedge; returns at the negedge after the accept edge
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] sew);
    int t = 0;
    while (!bus.in_ready && t < 40) begin @(negedge clk); t++; end
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_sew = sew;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a = $urandom; bus.in_b = $urandom; bus.in_sew = 2'($urandom);
  endtask

  // Count edges until out_valid, logging the mux selects of every stepping cycle
  task automatic wait_result(output logic [31:0] res, output logic err, output int lat);
    q16.delete(); q32.delete();
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      q16.push_back(c16); q32.push_back(c32);
      @(posedge clk); @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) begin
      n_chk++;
      $display("FAIL timeout: out_valid never rose within %0d cycles", lat);
    end
    res = bus.out_result;
    err = bus.out_err;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_chk++; if ({bus.out_result, bus.out_err} !== 33'h0) $display("FAIL rst_result: got %h/%b want 0/0", bus.out_result, bus.out_err); else n_pass++;
    n_chk++; if ({op_a, op_b, sew_o, c16, c32} !== 72'h0) $display("FAIL rst_mux: got %h %h %b %b %h want all 0", op_a, op_b, sew_o, c16, c32); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_sew8();
    logic [31:0] a, b, r; logic e; int lat;
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 32'h04030201 : $urandom;
      b = (i == 0) ? 32'h05050505 : $urandom;
      start_op(a, b, 2'b00);
      wait_result(r, e, lat);
      n_chk++; if (r !== ref_mul(a, b, 2'b00)) $display("FAIL sew8_result: got %h want %h", r, ref_mul(a, b, 2'b00)); else n_pass++;
      if (i == 0) begin
        n_chk++; if (r !== 32'h140F0A05) $display("FAIL sew8_directed: got %h want 140f0a05", r); else n_pass++;
      end
      n_chk++; if (e !== 1'b0) $display("FAIL sew8_err: got %b want 0", e); else n_pass++;
      n_chk++; if (lat != 2) $display("FAIL sew8_latency: got %0d want 2", lat); else n_pass++;
      for (int j = 0; j < q16.size(); j++) begin
        n_chk++; if (q16[j] !== {1'b0, 1'(j)}) $display("FAIL sew8_sel16[%0d]: got %b want %b", j, q16[j], {1'b0, 1'(j)}); else n_pass++;
      end
      consume();
      n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL sew8_ready_after: got %b want 1", bus.in_ready); else n_pass++;
    end
  endtask

  task automatic test_sew16();
    logic [31:0] a, b, r; logic e; int lat;
    for (int i = 0; i < 3; i++) begin
      a = (i == 0) ? 32'hFFFF1234 : $urandom;
      b = (i == 0) ? 32'h00020010 : $urandom;
      start_op(a, b, 2'b01);
      wait_result(r, e, lat);
      n_chk++; if (r !== ref_mul(a, b, 2'b01)) $display("FAIL sew16_result: got %h want %h", r, ref_mul(a, b, 2'b01)); else n_pass++;
      if (i == 0) begin
        n_chk++; if (r !== 32'hFFFE2340) $display("FAIL sew16_directed: got %h want fffe2340", r); else n_pass++;
      end
      n_chk++; if (e !== 1'b0) $display("FAIL sew16_err: got %b want 0", e); else n_pass++;
      n_chk++; if (lat != 4) $display("FAIL sew16_latency: got %0d want 4", lat); else n_pass++;
      for (int j = 0; j < q16.size(); j++) begin
        n_chk++; if (q16[j] !== 2'(j)) $display("FAIL sew16_sel16[%0d]: got %b want %b", j, q16[j], 2'(j)); else n_pass++;
      end
      consume();
    end
  endtask

  task automatic test_sew32();
    logic [31:0] a, b, r; logic e; int lat;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin a = 32'h12345678; b = 32'h00000010; end
        1: begin a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      start_op(a, b, 2'b10);
      wait_result(r, e, lat);
      n_chk++; if (r !== a * b) $display("FAIL sew32_result: got %h want %h", r, a * b); else n_pass++;
      if (i == 0) begin
        n_chk++; if (r !== 32'h23456780) $display("FAIL sew32_directed0: got %h want 23456780", r); else n_pass++;
      end
      if (i == 1) begin
        n_chk++; if (r !== 32'h00000001) $display("FAIL sew32_directed1: got %h want 00000001", r); else n_pass++;
      end
      n_chk++; if (lat != 16) $display("FAIL sew32_latency: got %0d want 16", lat); else n_pass++;
      for (int j = 0; j < q32.size(); j++) begin
        n_chk++; if (q32[j] !== 4'(j) || q16[j] !== 2'b00) $display("FAIL sew32_sel32[%0d]: got %h/%b want %h/00", j, q32[j], q16[j], 4'(j)); else n_pass++;
      end
      consume();
    end
  endtask

  task automatic test_sew_illegal();
    logic [31:0] r; logic e; int lat;
    start_op($urandom, $urandom, 2'b11);
    wait_result(r, e, lat);
    n_chk++; if (r !== 32'h0) $display("FAIL ill_result: got %h want 0", r); else n_pass++;
    n_chk++; if (e !== 1'b1) $display("FAIL ill_err: got %b want 1", e); else n_pass++;
    n_chk++; if (lat != 1) $display("FAIL ill_latency: got %0d want 1", lat); else n_pass++;
    consume();
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, r; logic e; int lat;
    a = $urandom; b = $urandom;
    start_op(a, b, 2'b10);
    wait_result(r, e, lat);
    bus.in_valid = 1'b1; bus.in_a = $urandom; bus.in_b = $urandom; bus.in_sew = 2'b00;
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      n_chk++; if (bus.out_valid !== 1'b1 || bus.out_result !== a * b) $display("FAIL bp_hold: got v=%b %h want v=1 %h", bus.out_valid, bus.out_result, a * b); else n_pass++;
      n_chk++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); else n_pass++;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    n_chk++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_release: got v=%b busy=%b want 0/0", bus.out_valid, busy); else n_pass++;
    n_chk++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_after: got %b want 1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b, r; logic e; int lat; logic seen;
    start_op($urandom, $urandom, 2'b10);
    repeat (5) begin @(posedge clk); @(negedge clk); end
    n_chk++; if (c32 !== 4'd5) $display("FAIL rmid_step: got %0d want 5", c32); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if ({bus.out_valid, busy, bus.out_err} !== 3'b000 || bus.in_ready !== 1'b1) $display("FAIL rmid_ctrl: got v=%b busy=%b err=%b rdy=%b want 0/0/0/1", bus.out_valid, busy, bus.out_err, bus.in_ready); else n_pass++;
    n_chk++; if ({bus.out_result, op_a, op_b, sew_o, c16, c32} !== 104'h0) $display("FAIL rmid_data: got %h %h %h %b %b %h want all 0", bus.out_result, op_a, op_b, sew_o, c16, c32); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (bus.out_valid) seen = 1'b1; end
    n_chk++; if (seen !== 1'b0) $display("FAIL rmid_no_valid: got %b want 0", seen); else n_pass++;
    a = $urandom; b = $urandom;
    start_op(a, b, 2'b00);
    wait_result(r, e, lat);
    n_chk++; if (r !== ref_mul(a, b, 2'b00) || lat != 2) $display("FAIL rmid_after: got %h lat %0d want %h lat 2", r, lat, ref_mul(a, b, 2'b00)); else n_pass++;
    consume();
  endtask

  task automatic test_flush();
    logic [31:0] a, b, r; logic e; int lat; logic seen;
    start_op($urandom, $urandom, 2'b01);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    n_chk++; if (busy !== 1'b0 || bus.in_ready !== 1'b1 || c16 !== 2'b00) $display("FAIL flush_idle: got busy=%b rdy=%b c16=%b want 0/1/00", busy, bus.in_ready, c16); else n_pass++;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (bus.out_valid) seen = 1'b1; end
    n_chk++; if (seen !== 1'b0) $display("FAIL flush_no_valid: got %b want 0", seen); else n_pass++;
    bus.in_valid = 1'b1; bus.in_sew = 2'b00; flush = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0; flush = 1'b0;
    n_chk++; if (busy !== 1'b0) $display("FAIL flush_vs_accept: got busy=%b want 0", busy); else n_pass++;
    a = $urandom; b = $urandom;
    start_op(a, b, 2'b01);
    wait_result(r, e, lat);
    n_chk++; if (r !== ref_mul(a, b, 2'b01)) $display("FAIL flush_after: got %h want %h", r, ref_mul(a, b, 2'b01)); else n_pass++;
    consume();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, r; logic e; int lat; logic [1:0] s;
    for (int i = 0; i < 16; i++) begin
      a = $urandom; b = $urandom; s = 2'($urandom_range(0, 3));
      start_op(a, b, s);
      wait_result(r, e, lat);
      n_chk++; if (r !== ref_mul(a, b, s) || e !== (s == 2'b11) || lat != steps(s)) $display("FAIL b2b[%0d] sew=%b: got %h err=%b lat=%0d want %h err=%b lat=%0d", i, s, r, e, lat, ref_mul(a, b, s), (s == 2'b11), steps(s)); else n_pass++;
      consume();
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_sew = '0; bus.out_ready = 1'b0;
    test_reset();
    test_sew8();
    test_sew16();
    test_sew32();
    test_sew_illegal();
    test_backpressure();
    test_reset_mid();
    test_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
